// File: rtl/hpdcache_mem_write_arb.sv
// rtl/hpdcache_mem_write_arb.sv - memory write channel arbiter for NREQ write sources
// Round-robin request arbitration; an order FIFO keeps write data in request order.
module hpdcache_mem_write_arb #(
    parameter  int NREQ         = 2,
    parameter  int META_WIDTH   = 64,
    parameter  int MEM_ID_WIDTH = 8,
    parameter  int DATA_WIDTH   = 512,
    parameter  int FIFO_DEPTH   = 4,
    localparam int IDX_W        = $clog2(NREQ),
    localparam int UP_ID_W      = MEM_ID_WIDTH - IDX_W,
    localparam int BE_W         = DATA_WIDTH / 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,

    input  logic [NREQ-1:0]            req_valid_i,
    output logic [NREQ-1:0]            req_ready_o,
    input  logic [NREQ*META_WIDTH-1:0] req_meta_i,
    input  logic [NREQ*UP_ID_W-1:0]    req_id_i,

    input  logic [NREQ-1:0]            data_valid_i,
    output logic [NREQ-1:0]            data_ready_o,
    input  logic [NREQ*DATA_WIDTH-1:0] data_i,
    input  logic [NREQ*BE_W-1:0]       data_be_i,
    input  logic [NREQ-1:0]            data_last_i,

    output logic [NREQ-1:0]            resp_valid_o,
    input  logic [NREQ-1:0]            resp_ready_i,
    output logic [UP_ID_W-1:0]         resp_id_o,
    output logic                       resp_error_o,

    output logic                       mem_req_valid_o,
    input  logic                       mem_req_ready_i,
    output logic [META_WIDTH-1:0]      mem_req_meta_o,
    output logic [MEM_ID_WIDTH-1:0]    mem_req_id_o,

    output logic                       mem_data_valid_o,
    input  logic                       mem_data_ready_i,
    output logic [DATA_WIDTH-1:0]      mem_data_o,
    output logic [BE_W-1:0]            mem_data_be_o,
    output logic                       mem_data_last_o,

    input  logic                       mem_resp_valid_i,
    output logic                       mem_resp_ready_o,
    input  logic [MEM_ID_WIDTH-1:0]    mem_resp_id_i,
    input  logic                       mem_resp_error_i
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    logic [IDX_W-1:0] rr_q, rr_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic             lock_q, lock_d;
    logic [IDX_W-1:0] fifo_q [FIFO_DEPTH];
    logic [IDX_W-1:0] fifo_d [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [IDX_W-1:0] grant, grant_hi, grant_lo, head, resp_tgt;
    logic             found_hi, fifo_full, fifo_empty, req_hs, pop, resp_tgt_ok;

    assign fifo_full  = (cnt_q == DEPTH_C);
    assign fifo_empty = (cnt_q == '0);
    assign head       = fifo_q[rd_ptr_q];

    // Lowest valid index at/after rr wins; otherwise wrap to the lowest valid index.
    always_comb begin
        grant_hi = '0;
        grant_lo = '0;
        found_hi = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_valid_i[k]) begin
                grant_lo = IDX_W'(k);
                if (IDX_W'(k) >= rr_q) begin
                    grant_hi = IDX_W'(k);
                    found_hi = 1'b1;
                end
            end
        end
        grant = lock_q ? grant_q : (found_hi ? grant_hi : grant_lo);
    end

    assign mem_req_valid_o = (|req_valid_i) & ~fifo_full;
    assign req_hs          = mem_req_valid_o & mem_req_ready_i;

    always_comb begin
        req_ready_o    = '0;
        mem_req_meta_o = '0;
        mem_req_id_o   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (grant == IDX_W'(k)) begin
                req_ready_o[k] = mem_req_valid_o & mem_req_ready_i;
                mem_req_meta_o = req_meta_i[k*META_WIDTH +: META_WIDTH];
                mem_req_id_o   = {IDX_W'(k), req_id_i[k*UP_ID_W +: UP_ID_W]};
            end
        end
    end

    always_comb begin
        data_ready_o     = '0;
        mem_data_valid_o = 1'b0;
        mem_data_o       = '0;
        mem_data_be_o    = '0;
        mem_data_last_o  = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (head == IDX_W'(k)) begin
                data_ready_o[k]  = ~fifo_empty & mem_data_ready_i;
                mem_data_valid_o = ~fifo_empty & data_valid_i[k];
                mem_data_o       = data_i[k*DATA_WIDTH +: DATA_WIDTH];
                mem_data_be_o    = data_be_i[k*BE_W +: BE_W];
                mem_data_last_o  = data_last_i[k];
            end
        end
    end

    assign pop = mem_data_valid_o & mem_data_ready_i & mem_data_last_o;

    always_comb begin
        rr_d     = rr_q;
        grant_d  = grant_q;
        lock_d   = lock_q;
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (req_hs) begin
            fifo_d[wr_ptr_q] = grant;
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
            rr_d             = (grant == IDX_W'(NREQ - 1)) ? '0 : grant + IDX_W'(1);
            lock_d           = 1'b0;
        end else if (mem_req_valid_o) begin
            // Payload must stay put until the downstream accepts it.
            lock_d  = 1'b1;
            grant_d = grant;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        cnt_d = cnt_q + CNT_W'(req_hs) - CNT_W'(pop);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_q     <= '0;
            grant_q  <= '0;
            lock_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            rr_q     <= rr_d;
            grant_q  <= grant_d;
            lock_q   <= lock_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        fifo_q <= fifo_d;
    end

    // Responses are steered by the index tag carried in the upper ID bits.
    assign resp_tgt     = mem_resp_id_i[MEM_ID_WIDTH-1 -: IDX_W];
    assign resp_tgt_ok  = ({1'b0, resp_tgt} < (IDX_W + 1)'(NREQ));
    assign resp_id_o    = mem_resp_id_i[UP_ID_W-1:0];
    assign resp_error_o = mem_resp_error_i;

    always_comb begin
        resp_valid_o     = '0;
        mem_resp_ready_o = 1'b1;
        for (int k = 0; k < NREQ; k++) begin
            if (resp_tgt == IDX_W'(k)) begin
                resp_valid_o[k]  = mem_resp_valid_i;
                mem_resp_ready_o = resp_ready_i[k];
            end
        end
    end

    resp_tgt_in_range: assert property (@(posedge clk_i) disable iff (rst_i)
        mem_resp_valid_i |-> resp_tgt_ok);

endmodule

// File: tb/tb_hpdcache_mem_write_arb.sv
// tb/tb_hpdcache_mem_write_arb.sv - bench for hpdcache_mem_write_arb
// Queue-based reference model checked every cycle, plus directed literal checks.
module tb_hpdcache_mem_write_arb;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [1:0]    req_valid, data_valid, data_last, resp_ready;
    logic [127:0]  req_meta;
    logic [13:0]   req_id;
    logic [1023:0] data;
    logic [127:0]  be;
    logic          mem_req_ready, mem_data_ready, mem_resp_valid, mem_resp_error;
    logic [7:0]    mem_resp_id;

    logic [1:0]    req_ready_o, data_ready_o, resp_valid_o;
    logic [6:0]    resp_id_o;
    logic          resp_error_o, mem_req_valid_o, mem_data_valid_o, mem_data_last_o, mem_resp_ready_o;
    logic [63:0]   mem_req_meta_o;
    logic [7:0]    mem_req_id_o;
    logic [511:0]  mem_data_o;
    logic [63:0]   mem_data_be_o;

    hpdcache_mem_write_arb dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready_o),
        .req_meta_i(req_meta), .req_id_i(req_id),
        .data_valid_i(data_valid), .data_ready_o(data_ready_o),
        .data_i(data), .data_be_i(be), .data_last_i(data_last),
        .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready),
        .resp_id_o(resp_id_o), .resp_error_o(resp_error_o),
        .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready),
        .mem_req_meta_o(mem_req_meta_o), .mem_req_id_o(mem_req_id_o),
        .mem_data_valid_o(mem_data_valid_o), .mem_data_ready_i(mem_data_ready),
        .mem_data_o(mem_data_o), .mem_data_be_o(mem_data_be_o), .mem_data_last_o(mem_data_last_o),
        .mem_resp_valid_i(mem_resp_valid), .mem_resp_ready_o(mem_resp_ready_o),
        .mem_resp_id_i(mem_resp_id), .mem_resp_error_i(mem_resp_error)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input logic [63:0] m, input logic [6:0] id);
        req_meta[k*64 +: 64] = m;
        req_id[k*7 +: 7]     = id;
    endtask

    task automatic set_data(input int k, input logic [63:0] v);
        data[k*512 +: 512] = {8{v}};
        be[k*64 +: 64]     = ~v;
    endtask

    // Reference model: rr pointer, lock, and the order of granted requesters as a queue.
    int m_rr, m_grant;
    bit m_lock;
    int m_q[$];

    always @(negedge clk) begin
        int g, h, t;
        bit ev, edv;
        logic [1:0] erdy, edr, erv;
        if (rst) begin
            m_rr = 0; m_lock = 0; m_grant = 0;
            m_q.delete();
        end else begin
            g = m_rr;
            if (m_lock) g = m_grant;
            else for (int i = 1; i >= 0; i--) if (req_valid[(m_rr + i) % 2]) g = (m_rr + i) % 2;
            ev   = (req_valid != 2'b00) && (m_q.size() < 4);
            erdy = 2'b00;
            if (ev && mem_req_ready) erdy[g] = 1'b1;
            chk("req_valid", mem_req_valid_o, ev);
            chk("req_ready", req_ready_o, erdy);
            if (ev) begin
                chk("req_meta", mem_req_meta_o, req_meta[g*64 +: 64]);
                chk("req_id", mem_req_id_o, {g[0], req_id[g*7 +: 7]});
            end

            h   = (m_q.size() > 0) ? m_q[0] : 0;
            edv = (m_q.size() > 0) && data_valid[h];
            edr = 2'b00;
            if (m_q.size() > 0 && mem_data_ready) edr[h] = 1'b1;
            chk("data_valid", mem_data_valid_o, edv);
            chk("data_ready", data_ready_o, edr);
            if (edv) begin
                chk("data", mem_data_o, data[h*512 +: 512]);
                chk("data_be", mem_data_be_o, be[h*64 +: 64]);
                chk("data_last", mem_data_last_o, data_last[h]);
            end

            t   = int'(mem_resp_id[7]);
            erv = 2'b00;
            if (mem_resp_valid) erv[t] = 1'b1;
            chk("resp_valid", resp_valid_o, erv);
            chk("resp_ready", mem_resp_ready_o, resp_ready[t]);
            chk("resp_id", resp_id_o, mem_resp_id[6:0]);
            chk("resp_err", resp_error_o, mem_resp_error);

            if (edv && mem_data_ready && data_last[h]) void'(m_q.pop_front());
            if (ev && mem_req_ready) begin
                m_q.push_back(g);
                m_rr = (g + 1) % 2;
                m_lock = 0;
            end else if (ev) begin
                m_lock = 1;
                m_grant = g;
            end
        end
    end

    localparam logic [63:0] M0 = 64'hA0A0_0000_0000_0001;
    localparam logic [63:0] M1 = 64'hB1B1_0000_0000_0002;
    localparam logic [63:0] D0 = 64'hD000_0000_0000_00D0;
    localparam logic [63:0] D1 = 64'hD111_0000_0000_00D1;

    initial begin
        rst = 1'b1;
        req_valid = '0; data_valid = '0; data_last = '0; resp_ready = '0;
        req_meta = '0; req_id = '0; data = '0; be = '0;
        mem_req_ready = 1'b0; mem_data_ready = 1'b0;
        mem_resp_valid = 1'b0; mem_resp_error = 1'b0; mem_resp_id = '0;
        adv(); adv();
        rst = 1'b0;
        settle();
        chk("rst_req_valid", mem_req_valid_o, 1'b0);
        chk("rst_data_valid", mem_data_valid_o, 1'b0);
        chk("rst_req_ready", req_ready_o, 2'b00);
        chk("rst_data_ready", data_ready_o, 2'b00);
        adv();

        // Alternating grants with both requesters valid
        set_req(0, M0, 7'h11);
        set_req(1, M1, 7'h22);
        set_data(0, D0);
        set_data(1, D1);
        req_valid = 2'b11; mem_req_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("alt_id", mem_req_id_o, (i % 2) ? 8'hA2 : 8'h11);
            adv();
        end
        req_valid = 2'b00; data_valid = 2'b11; data_last = 2'b11; mem_data_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("drain_head", mem_data_o[63:0], (i % 2) ? D1 : D0);
            adv();
        end

        // Lock: rr moves to 1, then req0 is held while req1 also asks
        req_valid = 2'b01;
        adv();
        mem_req_ready = 1'b0;
        settle();
        chk("lock_first", mem_req_id_o, 8'h11);
        adv();
        req_valid = 2'b11;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("lock_id", mem_req_id_o, 8'h11);
            chk("lock_meta", mem_req_meta_o, M0);
            adv();
        end
        mem_req_ready = 1'b1;
        settle();
        chk("lock_release", req_ready_o, 2'b01);
        adv();
        settle();
        chk("lock_next", mem_req_id_o, 8'hA2);
        adv();
        req_valid = 2'b00;
        adv();
        data_valid = 2'b00; data_last = 2'b00;

        // FIFO full stall and no bypass on the popping cycle
        mem_data_ready = 1'b0; req_valid = 2'b01;
        for (int i = 0; i < 4; i++) adv();
        settle();
        chk("full_valid", mem_req_valid_o, 1'b0);
        chk("full_ready", req_ready_o, 2'b00);
        adv();
        data_valid = 2'b01; data_last = 2'b01; mem_data_ready = 1'b1;
        settle();
        chk("full_pop_dv", mem_data_valid_o, 1'b1);
        chk("full_no_bypass", mem_req_valid_o, 1'b0);
        adv();
        mem_data_ready = 1'b0;
        settle();
        chk("after_pop_valid", mem_req_valid_o, 1'b1);
        chk("after_pop_ready", req_ready_o, 2'b01);
        adv();
        req_valid = 2'b00; mem_data_ready = 1'b1;
        for (int i = 0; i < 4; i++) adv();
        data_valid = 2'b00; data_last = 2'b00;

        // Data follows request order: req1 (2 beats) before req0
        req_valid = 2'b10; data_valid = 2'b01; data_last = 2'b01;
        settle();
        chk("ord_empty", mem_data_valid_o, 1'b0);
        adv();
        req_valid = 2'b01;
        settle();
        chk("ord_blocked0", mem_data_valid_o, 1'b0);
        adv();
        req_valid = 2'b00;
        settle();
        chk("ord_blocked1", mem_data_valid_o, 1'b0);
        adv();
        set_data(1, 64'hE1E1_0000_0000_000A);
        data_valid = 2'b11; data_last = 2'b01;
        settle();
        chk("ord_b0_dv", mem_data_valid_o, 1'b1);
        chk("ord_b0_data", mem_data_o[63:0], 64'hE1E1_0000_0000_000A);
        chk("ord_b0_last", mem_data_last_o, 1'b0);
        chk("ord_b0_rdy", data_ready_o, 2'b10);
        adv();
        set_data(1, 64'hE1E1_0000_0000_000B);
        data_last = 2'b11;
        settle();
        chk("ord_b1_data", mem_data_o[63:0], 64'hE1E1_0000_0000_000B);
        chk("ord_b1_last", mem_data_last_o, 1'b1);
        adv();
        settle();
        chk("ord_req0_data", mem_data_o[63:0], D0);
        chk("ord_req0_rdy", data_ready_o, 2'b01);
        adv();
        data_valid = 2'b00; data_last = 2'b00;

        // Response steering
        mem_resp_valid = 1'b1; mem_resp_id = 8'h85; mem_resp_error = 1'b1; resp_ready = 2'b01;
        settle();
        chk("resp85_valid", resp_valid_o, 2'b10);
        chk("resp85_id", resp_id_o, 7'h05);
        chk("resp85_err", resp_error_o, 1'b1);
        chk("resp85_ready", mem_resp_ready_o, 1'b0);
        adv();
        mem_resp_id = 8'h05; mem_resp_error = 1'b0;
        settle();
        chk("resp05_valid", resp_valid_o, 2'b01);
        chk("resp05_ready", mem_resp_ready_o, 1'b1);
        adv();
        mem_resp_valid = 1'b0;

        // Reset with two entries pending and rr at 1
        mem_data_ready = 1'b0; req_valid = 2'b10;
        adv();
        req_valid = 2'b01;
        adv();
        req_valid = 2'b00; data_valid = 2'b11;
        settle();
        chk("pre_rst_dv", mem_data_valid_o, 1'b1);
        adv();
        rst = 1'b1; data_valid = 2'b00;
        adv();
        rst = 1'b0; req_valid = 2'b11; data_valid = 2'b11; mem_req_ready = 1'b0;
        settle();
        chk("rst_dv", mem_data_valid_o, 1'b0);
        chk("rst_tie_id", mem_req_id_o, 8'h11);
        adv();
        req_valid = 2'b00; data_valid = 2'b00;
        adv();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
